// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the single-cycle MIPS datapath. This file holds the memory
//   arbiter additions:
//     arbstate_t       - arbiter FSM states
//     acckind_t        - kind of the access latched at grant time
//     ARB_TIMEOUT_WORD - read data returned when an access times out
//     acc_is_read()    - true for accesses that return load data
// -----------------------------------------------------------------------------
package cpu_types_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IACC,
      DACC,
      DONE
   } arbstate_t;

   typedef enum logic [1:0] {
      ACC_IFETCH,
      ACC_DREAD,
      ACC_DWRITE
   } acckind_t;

   localparam logic [31:0] ARB_TIMEOUT_WORD = 32'hBAD1BAD1;

   function automatic logic acc_is_read(input acckind_t k);
      return (k != ACC_DWRITE);
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// -----------------------------------------------------------------------------
// arb_timeout_counter
//   Saturating up-counter with synchronous clear. o_expired is high while the
//   count equals MAX; the count never wraps.
//   Ports:
//     i_clk      clock
//     i_rst      synchronous active-high reset (count -> 0)
//     i_clr      synchronous clear (count -> 0), wins over i_inc
//     i_inc      increment enable
//     o_expired  count == MAX
// -----------------------------------------------------------------------------
module arb_timeout_counter #(
   parameter int MAX = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CW-1:0] r_cnt;

   assign o_expired = (r_cnt == CW'(MAX));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_expired) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one single-ported RAM between instruction fetch and data access.
//   One request is latched per access; RAM strobes come from registered state;
//   completion is reported by a one-cycle ihit/dhit pulse with registered load
//   data. An access with no ramready is aborted and sets the sticky err flag.
//
//   Optional feature macro: ARB_FAIRNESS_EN
//     defined   - after STARVE_MAX consecutive data grants made while iREN is
//                 high, the next arbitration goes to the instruction path.
//     undefined - strict data priority.
//
//   Ports:
//     CLK, RST                  clock, synchronous active-high reset
//     iREN, iaddr               instruction read request / address
//     ihit, iload               fetch complete pulse / fetched word (held)
//     dREN, dWEN, daddr, dstore data read/write request, address, write data
//     dhit, dload               data complete pulse / loaded word (held)
//     ramREN, ramWEN            RAM strobes
//     ramaddr, ramstore         RAM address / write data (0 outside accesses)
//     ramload, ramready         RAM read data / completion pulse
//     err                       sticky timeout flag
// -----------------------------------------------------------------------------
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT    = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        err
);

   arbstate_t   r_state;
   acckind_t    r_kind;
   logic [31:0] r_addr;
   logic [31:0] r_store;
   logic [31:0] r_iload;
   logic [31:0] r_dload;
   logic        r_err;

   arbstate_t   w_next;
   logic        w_grant;
   acckind_t    w_gkind;
   logic        w_capture;
   logic        w_abort;
   logic        w_acc;
   logic        w_tmo_exp;
   logic        w_starved;
   logic [31:0] w_rdata;

   assign w_acc = (r_state == IACC) || (r_state == DACC);

   // The count holds the wait cycles already spent in the access (0 in the
   // first strobe cycle). It passes TIMEOUT-1 with no ramready and the abort
   // fires on the following cycle, placing the hit TIMEOUT+1 cycles after the
   // first strobe cycle.
   arb_timeout_counter #(.MAX(TIMEOUT)) u_tmo (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_clr     (w_grant),
      .i_inc     (w_acc),
      .o_expired (w_tmo_exp)
   );

`ifdef ARB_FAIRNESS_EN
   logic w_stv_inc;
   logic w_stv_clr;

   // Only data grants that pass over a waiting fetch count toward starvation.
   always_comb begin
      w_stv_inc = w_grant && (w_gkind != ACC_IFETCH) && iREN;
      w_stv_clr = w_grant && !w_stv_inc;
   end

   arb_timeout_counter #(.MAX(STARVE_MAX)) u_stv (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_clr     (w_stv_clr),
      .i_inc     (w_stv_inc),
      .o_expired (w_starved)
   );
`else
   assign w_starved = 1'b0;
`endif

   // Next-state and grant decision.
   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_gkind   = ACC_IFETCH;
      w_capture = 1'b0;
      w_abort   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_starved && iREN) begin
               w_grant = 1'b1;
               w_gkind = ACC_IFETCH;
               w_next  = IACC;
            end else if (dWEN) begin
               // dREN together with dWEN is served as a write
               w_grant = 1'b1;
               w_gkind = ACC_DWRITE;
               w_next  = DACC;
            end else if (dREN) begin
               w_grant = 1'b1;
               w_gkind = ACC_DREAD;
               w_next  = DACC;
            end else if (iREN) begin
               w_grant = 1'b1;
               w_gkind = ACC_IFETCH;
               w_next  = IACC;
            end
         end
         IACC, DACC: begin
            // ramready wins if it coincides with the timeout
            if (ramready) begin
               w_capture = 1'b1;
               w_next    = DONE;
            end else if (w_tmo_exp) begin
               w_abort = 1'b1;
               w_next  = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_rdata = w_capture ? ramload : ARB_TIMEOUT_WORD;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_kind  <= ACC_IFETCH;
         r_addr  <= '0;
         r_store <= '0;
         r_iload <= '0;
         r_dload <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_kind <= w_gkind;
            if (w_gkind == ACC_IFETCH) begin
               r_addr  <= iaddr;
               r_store <= '0;
            end else begin
               r_addr  <= daddr;
               r_store <= dstore;
            end
         end
         if ((w_capture || w_abort) && acc_is_read(r_kind)) begin
            if (r_kind == ACC_IFETCH) r_iload <= w_rdata;
            else                      r_dload <= w_rdata;
         end
         if (w_abort) r_err <= 1'b1;
      end
   end

   assign ramREN   = w_acc && acc_is_read(r_kind);
   assign ramWEN   = (r_state == DACC) && (r_kind == ACC_DWRITE);
   assign ramaddr  = w_acc ? r_addr  : '0;
   assign ramstore = w_acc ? r_store : '0;
   assign ihit     = (r_state == DONE) && (r_kind == ACC_IFETCH);
   assign dhit     = (r_state == DONE) && (r_kind != ACC_IFETCH);
   assign iload    = r_iload;
   assign dload    = r_dload;
   assign err      = r_err;

endmodule
